i2c_wb_sequencer: RTL and testbench

//  Wishbone master that configures and sequences the i2c_master_top core (PRER/CTR/TXR/RXR/CR/SR map).

---
 rtl/i2c_wb_sequencer.sv | 166 ++++++++++++++++
 tb/tb_i2c_wb_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_wb_sequencer.sv
// rtl/i2c_wb_sequencer.sv - Wishbone master sequencing i2c_master_top byte-register transactions.
// Optional poll watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_wb_sequencer #(
    parameter logic [15:0] PRESCALE       = 16'd199,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rnw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic       init_done,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    input  logic       wb_ack_i
);
    localparam logic [3:0] S_INIT_PLO  = 4'd0,  S_INIT_PHI = 4'd1,  S_INIT_CTR = 4'd2,
                           S_IDLE      = 4'd3,  S_LD_TXR   = 4'd4,  S_LD_CR    = 4'd5,
                           S_POLL      = 4'd6,  S_CHECK    = 4'd7,  S_RD_RXR   = 4'd8,
                           S_STOP      = 4'd9,  S_STOP_POLL = 4'd10, S_RESP    = 4'd11;

    logic [3:0] r_state;
    logic [1:0] r_step;
    logic       r_rnw;
    logic [6:0] r_dev;
    logic [7:0] r_reg, r_wdata, r_rdata;
    logic [1:0] r_err;
    logic       r_al, r_rxack, r_init_done;
    logic       r_cyc, r_we;
    logic [2:0] r_adr;
    logic [7:0] r_dat;

    logic       w_acc_en, w_acc_we, w_ack, w_tmo_hit;
    logic [2:0] w_acc_adr;
    logic [7:0] w_acc_dat, w_txr, w_cr;

    assign w_ack     = r_cyc && wb_ack_i;
    assign req_ready = (r_state == S_IDLE) && r_init_done;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign init_done = r_init_done;
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;
    assign wb_we_o   = r_we;
    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = TIMEOUT_CYCLES[15:0];
    logic        w_polling;
    logic [15:0] r_tmo_cnt;
    assign w_polling = (r_state == S_POLL) || (r_state == S_STOP_POLL);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_tmo_cnt <= 16'd0;
        else if (!w_polling)         r_tmo_cnt <= 16'd0;
        else if (r_tmo_cnt != 16'hFFFF) r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
    // Only give up between accesses so an in-flight read is never cut short.
    assign w_tmo_hit = w_polling && !r_cyc && (r_tmo_cnt >= TMO_LIMIT);
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_txr = 8'h00;
        w_cr  = 8'h00;
        case (r_step)
            2'd0: begin w_txr = {r_dev, 1'b0}; w_cr = 8'h90; end
            2'd1: begin w_txr = r_reg;         w_cr = 8'h10; end
            2'd2: begin w_txr = r_rnw ? {r_dev, 1'b1} : r_wdata; w_cr = r_rnw ? 8'h90 : 8'h50; end
            default: begin w_txr = 8'h00;      w_cr = 8'h68; end
        endcase
    end

    always_comb begin
        w_acc_en  = 1'b1;
        w_acc_we  = 1'b1;
        w_acc_adr = 3'd0;
        w_acc_dat = 8'h00;
        case (r_state)
            S_INIT_PLO:  begin w_acc_adr = 3'd0; w_acc_dat = PRESCALE[7:0];  end
            S_INIT_PHI:  begin w_acc_adr = 3'd1; w_acc_dat = PRESCALE[15:8]; end
            S_INIT_CTR:  begin w_acc_adr = 3'd2; w_acc_dat = 8'h80;          end
            S_LD_TXR:    begin w_acc_adr = 3'd3; w_acc_dat = w_txr;          end
            S_LD_CR:     begin w_acc_adr = 3'd4; w_acc_dat = w_cr;           end
            S_STOP:      begin w_acc_adr = 3'd4; w_acc_dat = 8'h40;          end
            S_POLL, S_STOP_POLL: begin w_acc_we = 1'b0; w_acc_adr = 3'd4;    end
            S_RD_RXR:    begin w_acc_we = 1'b0; w_acc_adr = 3'd3;            end
            default:     w_acc_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT_PLO;  r_step <= 2'd0;   r_rnw <= 1'b0;   r_dev <= 7'd0;
            r_reg <= 8'h00;         r_wdata <= 8'h00; r_rdata <= 8'h00; r_err <= 2'b00;
            r_al <= 1'b0;           r_rxack <= 1'b0;  r_init_done <= 1'b0;
            r_cyc <= 1'b0;          r_we <= 1'b0;     r_adr <= 3'd0;   r_dat <= 8'h00;
        end else begin
            // Bus signals drop right after the ack; the next access waits one idle cycle.
            if (w_ack) begin
                r_cyc <= 1'b0; r_we <= 1'b0; r_adr <= 3'd0; r_dat <= 8'h00;
            end else if (!r_cyc && w_acc_en && !w_tmo_hit) begin
                r_cyc <= 1'b1; r_we <= w_acc_we; r_adr <= w_acc_adr; r_dat <= w_acc_dat;
            end
            case (r_state)
                S_INIT_PLO: if (w_ack) r_state <= S_INIT_PHI;
                S_INIT_PHI: if (w_ack) r_state <= S_INIT_CTR;
                S_INIT_CTR: if (w_ack) begin r_init_done <= 1'b1; r_state <= S_IDLE; end
                S_IDLE: if (req_valid && r_init_done) begin
                    r_rnw <= req_rnw; r_dev <= req_dev; r_reg <= req_reg; r_wdata <= req_wdata;
                    r_step <= 2'd0; r_err <= 2'b00; r_state <= S_LD_TXR;
                end
                S_LD_TXR: if (w_ack) r_state <= S_LD_CR;
                S_LD_CR:  if (w_ack) r_state <= S_POLL;
                S_POLL: begin
                    if (w_tmo_hit) begin
                        r_err <= 2'b11; r_state <= S_STOP;
                    end else if (w_ack) begin
                        r_al <= wb_dat_i[5]; r_rxack <= wb_dat_i[7];
                        if (!wb_dat_i[1]) r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_step == 2'd3) begin
                        r_state <= S_RD_RXR;
                    end else if (r_al) begin
                        r_err <= 2'b10; r_rdata <= 8'h00; r_state <= S_RESP;
                    end else if (r_rxack) begin
                        r_err <= 2'b01; r_state <= S_STOP;
                    end else if (r_step == 2'd2 && !r_rnw) begin
                        r_rdata <= 8'h00; r_state <= S_RESP;
                    end else begin
                        r_step  <= r_step + 2'd1;
                        r_state <= (r_step == 2'd2) ? S_LD_CR : S_LD_TXR;
                    end
                end
                S_RD_RXR: if (w_ack) begin r_rdata <= wb_dat_i; r_state <= S_RESP; end
                S_STOP: if (w_ack) begin
                    if (r_err == 2'b11) begin r_rdata <= 8'h00; r_state <= S_RESP; end
                    else r_state <= S_STOP_POLL;
                end
                S_STOP_POLL: begin
                    if (w_tmo_hit) begin
                        r_err <= 2'b11; r_state <= S_STOP;
                    end else if (w_ack && !wb_dat_i[6]) begin
                        r_rdata <= 8'h00; r_state <= S_RESP;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_INIT_PLO;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// tb/tb_i2c_wb_sequencer.sv - Scoreboard bench with an I2C core/slave model on the Wishbone port.
module tb_i2c_wb_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0, req_rnw = 1'b0;
    logic [6:0] req_dev = 7'd0;
    logic [7:0] req_reg = 8'h00, req_wdata = 8'h00;
    logic [7:0] wb_dat_i = 8'h00;
    logic       wb_ack_i = 1'b0;
    logic       req_ready, rsp_valid, init_done, wb_we_o, wb_cyc_o, wb_stb_o;
    logic [7:0] rsp_rdata, wb_dat_o;
    logic [1:0] rsp_err;
    logic [2:0] wb_adr_o;

    always #5 clk = ~clk;

    i2c_wb_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rnw(req_rnw), .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
    );

    localparam logic [6:0] PRESENT = 7'h50;

    int errors = 0;
    int checks = 0;
    logic [10:0] exp_wr[$];
    logic [9:0]  exp_rsp[$];
    logic [7:0]  last_rdata = 8'h00;

    // Environment: slave memory and core state.
    logic [7:0] mem[256];
    logic [7:0] ref_mem[256];
    logic [7:0] txr = 8'h00, ptr = 8'h00, rxr = 8'h00;
    logic       rxack = 1'b0, al = 1'b0, busy = 1'b0, stop_pending = 1'b0, inject_al = 1'b0;
    int         tip_left = 0, busy_left = 0, byte_idx = 0;
    int         ack_delay = -1, cnt = 0, cur_delay = 0;
    logic [2:0] cap_adr;
    logic       cap_we;
    logic [7:0] cap_dat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cr_write(input logic [7:0] cr);
        al = 1'b0;
        tip_left = $urandom_range(0, 3);
        if (cr[4]) begin
            if (cr[7]) begin
                rxack = (txr[7:1] != PRESENT);
                byte_idx = 1;
                if (inject_al) begin al = 1'b1; busy = 1'b0; end
                else busy = 1'b1;
            end else begin
                rxack = 1'b0;
                if (byte_idx == 1) ptr = txr;
                else mem[ptr] = txr;
                byte_idx++;
            end
        end
        if (cr[5]) rxr = mem[ptr];
        if (cr[6]) begin stop_pending = 1'b1; busy_left = $urandom_range(0, 2); end
    endtask

    task automatic core_access();
        logic [10:0] e;
        logic tip;
        if (wb_we_o) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL wb_write actual=%0h/%0h required=none", wb_adr_o, wb_dat_o);
            end else begin
                e = exp_wr.pop_front();
                if ({wb_adr_o, wb_dat_o} !== e) begin
                    errors++;
                    $display("FAIL wb_write actual=%0h required=%0h", {wb_adr_o, wb_dat_o}, e);
                end
            end
            if (wb_adr_o == 3'd3) txr = wb_dat_o;
            else if (wb_adr_o == 3'd4) cr_write(wb_dat_o);
        end else if (wb_adr_o == 3'd4) begin
            tip = (tip_left > 0);
            if (tip) tip_left--;
            if (stop_pending) begin
                if (busy_left > 0) busy_left--;
                else begin busy = 1'b0; stop_pending = 1'b0; end
            end
            wb_dat_i = {rxack, busy, al, 3'b000, tip, 1'b0};
        end else if (wb_adr_o == 3'd3) begin
            wb_dat_i = rxr;
        end else begin
            wb_dat_i = 8'h00;
        end
    endtask

    // Wishbone slave: registered ack after ack_delay (random 0..3 when negative).
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            wb_ack_i = 1'b0; cnt = 0; tip_left = 0; busy = 1'b0; busy_left = 0;
            stop_pending = 1'b0; al = 1'b0; rxack = 1'b0; byte_idx = 0;
        end else if (wb_ack_i) begin
            wb_ack_i = 1'b0;
            cnt = 0;
            chk("wb_drop_after_ack", {31'd0, wb_cyc_o}, 32'd0);
        end else if (wb_cyc_o) begin
            chk("wb_stb_eq_cyc", {31'd0, wb_stb_o}, 32'd1);
            if (cnt == 0) begin
                cap_adr = wb_adr_o; cap_we = wb_we_o; cap_dat = wb_dat_o;
                cur_delay = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
            end else begin
                chk("wb_stable", {20'd0, wb_adr_o, wb_we_o, wb_dat_o}, {20'd0, cap_adr, cap_we, cap_dat});
            end
            if (cnt == cur_delay) begin core_access(); wb_ack_i = 1'b1; end
            else cnt++;
        end
    end

    // Response monitor.
    initial forever begin
        logic [9:0] e;
        @(negedge clk);
        if (rst_n && rsp_valid) begin
            chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
            checks++;
            if (exp_rsp.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected actual=%0h/%0h required=none", rsp_err, rsp_rdata);
            end else begin
                e = exp_rsp.pop_front();
                if ({rsp_err, rsp_rdata} !== e) begin
                    errors++;
                    $display("FAIL rsp actual=%0h/%0h required=%0h/%0h", rsp_err, rsp_rdata, e[9:8], e[7:0]);
                end
                last_rdata = e[7:0];
            end
            @(negedge clk);
            chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        end
    end

    task automatic push_init();
        exp_wr.push_back({3'd0, 8'hC7});
        exp_wr.push_back({3'd1, 8'h00});
        exp_wr.push_back({3'd2, 8'h80});
    endtask

    // Reference: what a byte-register transaction must look like on the core bus.
    task automatic push_cmd(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                            input logic [7:0] wd, input logic lost);
        exp_wr.push_back({3'd3, dev, 1'b0});
        exp_wr.push_back({3'd4, 8'h90});
        if (lost) begin
            exp_rsp.push_back({2'b10, 8'h00});
        end else if (dev != PRESENT) begin
            exp_wr.push_back({3'd4, 8'h40});
            exp_rsp.push_back({2'b01, 8'h00});
        end else begin
            exp_wr.push_back({3'd3, rg});
            exp_wr.push_back({3'd4, 8'h10});
            if (!rnw) begin
                exp_wr.push_back({3'd3, wd});
                exp_wr.push_back({3'd4, 8'h50});
                ref_mem[rg] = wd;
                exp_rsp.push_back({2'b00, 8'h00});
            end else begin
                exp_wr.push_back({3'd3, dev, 1'b1});
                exp_wr.push_back({3'd4, 8'h90});
                exp_wr.push_back({3'd4, 8'h68});
                exp_rsp.push_back({2'b00, ref_mem[rg]});
            end
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 3000);
        chk(name, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic drive_req(input logic rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
        req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_cmd(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd, input logic lost, input logic extra);
        int n = 0;
        wait_ready("ready_before_cmd");
        chk("rsp_rdata_hold", {24'd0, rsp_rdata}, {24'd0, last_rdata});
        inject_al = lost;
        push_cmd(rnw, dev, rg, wd, lost);
        drive_req(rnw, dev, rg, wd);
        if (extra) begin
            repeat (20) @(negedge clk);
            chk("busy_not_ready", {31'd0, req_ready}, 32'd0);
            drive_req(1'b0, 7'h50, 8'($urandom), 8'($urandom));
        end
        while (exp_rsp.size() != 0 && n < 5000) begin @(negedge clk); n++; end
        chk("rsp_arrived", exp_rsp.size(), 32'd0);
        chk("wb_writes_consumed", exp_wr.size(), 32'd0);
        inject_al = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] old, rg, wd;
        logic [6:0] dev;
        logic rnw, lost;
        for (int i = 0; i < 256; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
        repeat (3) @(negedge clk);
        chk("reset_outputs", {7'd0, req_ready, rsp_valid, rsp_rdata, rsp_err, init_done,
            wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o}, 32'd0);
        push_init();
        rst_n = 1'b1;
        wait_ready("init_ready");
        chk("init_done", {31'd0, init_done}, 32'd1);
        chk("init_writes", exp_wr.size(), 32'd0);

        do_cmd(1'b0, 7'h50, 8'h12, 8'hA5, 1'b0, 1'b0);
        do_cmd(1'b0, 7'h50, 8'h12, 8'h3C, 1'b0, 1'b0);
        do_cmd(1'b1, 7'h50, 8'h12, 8'h00, 1'b0, 1'b0);
        do_cmd(1'b0, 7'h21, 8'h05, 8'h77, 1'b0, 1'b0);
        do_cmd(1'b1, 7'h21, 8'h05, 8'h00, 1'b0, 1'b0);
        do_cmd(1'b0, 7'h21, 8'h05, 8'h11, 1'b1, 1'b0);
        do_cmd(1'b1, 7'h50, 8'h12, 8'h00, 1'b1, 1'b0);
        ack_delay = 3;
        do_cmd(1'b0, 7'h50, 8'h40, 8'h5A, 1'b0, 1'b1);
        do_cmd(1'b1, 7'h50, 8'h40, 8'h00, 1'b0, 1'b0);
        ack_delay = -1;

        for (int k = 0; k < 24; k++) begin
            rnw  = 1'($urandom);
            dev  = ($urandom_range(0, 3) != 0) ? PRESENT : 7'($urandom_range(0, 79));
            rg   = 8'($urandom_range(0, 7));
            wd   = 8'($urandom);
            lost = ($urandom_range(0, 9) == 0);
            do_cmd(rnw, dev, rg, wd, lost, 1'b0);
        end

        wait_ready("ready_before_reset");
        old = ref_mem[8'h33];
        push_cmd(1'b0, PRESENT, 8'h33, 8'hEE, 1'b0);
        drive_req(1'b0, PRESENT, 8'h33, 8'hEE);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {7'd0, req_ready, rsp_valid, rsp_rdata, rsp_err, init_done,
            wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o}, 32'd0);
        exp_wr.delete();
        exp_rsp.delete();
        ref_mem[8'h33] = old;
        mem[8'h33] = old;
        last_rdata = 8'h00;
        repeat (3) @(negedge clk);
        push_init();
        rst_n = 1'b1;
        wait_ready("reinit_ready");
        chk("reinit_done", {31'd0, init_done}, 32'd1);
        chk("reinit_writes", exp_wr.size(), 32'd0);
        do_cmd(1'b1, 7'h50, 8'h33, 8'h00, 1'b0, 1'b0);
        do_cmd(1'b0, 7'h50, 8'h33, 8'h99, 1'b0, 1'b0);
        do_cmd(1'b1, 7'h50, 8'h33, 8'h00, 1'b0, 1'b0);

        repeat (10) @(negedge clk);
        chk("final_rsp_queue", exp_rsp.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
